// File: rtl/bus_grant_sequencer_pkg.sv
// Shared types for the bus grant sequencer.
// FSM state encoding and sticky error bit positions.
package bus_grant_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RELEASE
  } state_t;

  localparam int ERR_ADDR_TO = 0;
  localparam int ERR_TGT_TO  = 1;
  localparam int ERR_PROTO   = 2;

endpackage

// File: rtl/bus_grant_sequencer_rr_priority_pick.sv
// Round-robin pick: first request at or after last+1 (mod N).
// Returns one-hot grant, its index and an any-request flag.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  logic found;
  int   k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = W'(k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_grant_sequencer.sv
// Bus grant sequencer: round-robin grant, address/data phases,
// watchdog timeouts and sticky protocol error flags.
module bus_grant_sequencer #(
  parameter int DeviceMaxNumber = 4,
  parameter int TimeoutCycles   = 16
) (
  input  logic                               clk,
  input  logic                               Reset_n,
  input  logic [DeviceMaxNumber-1:0]         BARQ,
  input  logic                               AddressValid,
  input  logic                               TargetReady,
  input  logic                               DataStrobe,
  input  logic                               ErrClr,
  output logic [DeviceMaxNumber-1:0]         BAGD,
  output logic [$clog2(DeviceMaxNumber)-1:0] GrantId,
  output logic                               Busy,
  output logic [2:0]                         Error
);

  import bus_grant_sequencer_pkg::*;

  localparam int IW = $clog2(DeviceMaxNumber);
  localparam int WW = $clog2(TimeoutCycles + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TimeoutCycles - 1);
  localparam logic [WW-1:0] WD_SAT  = WW'(TimeoutCycles);

  state_t                     state;
  logic [IW-1:0]              last;
  logic [IW-1:0]              cur;
  logic [WW-1:0]              wd;
  logic [WW-1:0]              wd_inc;
  logic [DeviceMaxNumber-1:0] pick_oh;
  logic [IW-1:0]              pick_idx;
  logic                       pick_any;
  logic                       own;
  logic                       wd_hit;
  logic                       stall;
  logic [2:0]                 err_set;

  rr_priority_pick #(
    .N(DeviceMaxNumber)
  ) u_pick (
    .req  (BARQ),
    .last (last),
    .grant(pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign own    = BARQ[cur];
  assign wd_hit = (wd == WD_LAST);
  assign wd_inc = (wd == WD_SAT) ? wd : wd + 1'b1;
  assign stall  = DataStrobe && !TargetReady;

  always_comb begin
    err_set = '0;
    err_set[ERR_ADDR_TO] = (state == S_ADDR) && !AddressValid
                           && own && wd_hit;
    err_set[ERR_TGT_TO]  = (state == S_DATA) && own
                           && stall && wd_hit;
    err_set[ERR_PROTO]   = (DataStrobe && state != S_DATA)
                           || (AddressValid
                               && (state == S_IDLE
                                   || state == S_RELEASE));
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      BAGD    <= '0;
      GrantId <= '0;
      Busy    <= 1'b0;
      Error   <= '0;
      wd      <= '0;
      cur     <= '0;
      last    <= IW'(DeviceMaxNumber - 1);
    end else begin
      Error <= (Error & ~{3{ErrClr}}) | err_set;
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            state   <= S_ADDR;
            BAGD    <= pick_oh;
            GrantId <= pick_idx;
            cur     <= pick_idx;
            Busy    <= 1'b1;
            wd      <= '0;
          end
        end
        S_ADDR: begin
          if (AddressValid) begin
            state <= S_DATA;
            wd    <= '0;
          end else if (!own || wd_hit) begin
            state   <= S_RELEASE;
            BAGD    <= '0;
            GrantId <= '0;
            wd      <= '0;
          end else begin
            wd <= wd_inc;
          end
        end
        S_DATA: begin
          // a beat in the dropping cycle is simply accepted
          if (!own || (stall && wd_hit)) begin
            state   <= S_RELEASE;
            BAGD    <= '0;
            GrantId <= '0;
            wd      <= '0;
          end else if (stall) begin
            wd <= wd_inc;
          end else begin
            wd <= '0;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          last  <= cur;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Self-checking bench for bus_grant_sequencer against a
// transaction-level reference model.
module tb_bus_grant_sequencer;

  localparam int N = 4;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         Reset_n;
  logic [N-1:0] BARQ;
  logic         AddressValid;
  logic         TargetReady;
  logic         DataStrobe;
  logic         ErrClr;
  logic [N-1:0] BAGD;
  logic [1:0]   GrantId;
  logic         Busy;
  logic [2:0]   Error;

  int errors = 0;
  int checks = 0;

  // reference model: who owns the bus and what phase it is in
  int       owner;
  int       held;
  int       last;
  int       stall;
  bit       addr_ph;
  bit       turn;
  logic [2:0] merr;

  bus_grant_sequencer #(
    .DeviceMaxNumber(N),
    .TimeoutCycles  (T)
  ) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .BARQ        (BARQ),
    .AddressValid(AddressValid),
    .TargetReady (TargetReady),
    .DataStrobe  (DataStrobe),
    .ErrClr      (ErrClr),
    .BAGD        (BAGD),
    .GrantId     (GrantId),
    .Busy        (Busy),
    .Error       (Error)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    owner   = -1;
    held    = 0;
    last    = N - 1;
    stall   = 0;
    addr_ph = 1'b0;
    turn    = 1'b0;
    merr    = 3'b000;
  endtask

  task automatic release_bus();
    turn  = 1'b1;
    held  = owner;
    owner = -1;
  endtask

  task automatic model_step();
    logic [2:0] set;
    int k;
    set = 3'b000;
    if (DataStrobe && !(owner >= 0 && !addr_ph)) set[2] = 1'b1;
    if (AddressValid && owner < 0) set[2] = 1'b1;
    if (turn) begin
      turn = 1'b0;
      last = held;
    end else if (owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        k = (last + i) % N;
        if (owner < 0 && BARQ[k]) begin
          owner   = k;
          addr_ph = 1'b1;
          stall   = 0;
        end
      end
    end else if (addr_ph) begin
      if (AddressValid) begin
        addr_ph = 1'b0;
        stall   = 0;
      end else if (!BARQ[owner]) begin
        release_bus();
      end else begin
        stall++;
        if (stall == T) begin
          set[0] = 1'b1;
          release_bus();
        end
      end
    end else begin
      if (!BARQ[owner]) begin
        release_bus();
      end else if (DataStrobe && !TargetReady) begin
        stall++;
        if (stall == T) begin
          set[1] = 1'b1;
          release_bus();
        end
      end else begin
        stall = 0;
      end
    end
    merr = (ErrClr ? 3'b000 : merr) | set;
  endtask

  function automatic logic [9:0] model_out();
    logic [3:0] b;
    logic [1:0] g;
    logic       bz;
    b  = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
    g  = (owner >= 0) ? 2'(owner) : 2'b00;
    bz = (owner >= 0) || turn;
    return {b, g, bz, merr};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    BARQ         = '0;
    AddressValid = 1'b0;
    TargetReady  = 1'b0;
    DataStrobe   = 1'b0;
    ErrClr       = 1'b0;
  endtask

  task automatic settle();
    quiet();
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    quiet();
    Reset_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({BAGD, GrantId, Busy, Error} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b",
               {BAGD, GrantId, Busy, Error}, 10'b0);
    end
  endtask

  task automatic test_round_robin();
    BARQ = 4'b0101;
    @(posedge clk);
    #1 Reset_n = 1'b1;
    tick();
    checks++;
    if (BAGD !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first: got %b expected %b", BAGD, 4'b0001);
    end
    for (int c = 0; c < T + 2; c++) begin
      tick();
      checks++;
      if ({BAGD, GrantId, Busy, Error} !== model_out()) begin
        errors++;
        $display("FAIL rr_release cyc %0d: got %b expected %b", c,
                 {BAGD, GrantId, Busy, Error}, model_out());
      end
    end
    tick();
    checks++;
    if (BAGD !== 4'b0100 || GrantId !== 2'd2) begin
      errors++;
      $display("FAIL rr_second: got %b/%0d expected 0100/2",
               BAGD, GrantId);
    end
    settle();
  endtask

  task automatic test_transfer();
    BARQ = 4'b0100;
    tick();
    repeat (2) begin
      tick();
      checks++;
      if (Busy !== 1'b1 || BAGD !== 4'b0100) begin
        errors++;
        $display("FAIL xfer_addr: got %b/%b expected 1/0100",
                 Busy, BAGD);
      end
    end
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    DataStrobe   = 1'b1;
    TargetReady  = 1'b1;
    for (int b = 0; b < 5; b++) begin
      tick();
      checks++;
      if ({BAGD, GrantId, Busy, Error} !== model_out()
          || Busy !== 1'b1) begin
        errors++;
        $display("FAIL xfer_beat %0d: got %b expected %b", b,
                 {BAGD, GrantId, Busy, Error}, model_out());
      end
    end
    quiet();
    tick();
    checks++;
    if (BAGD !== 4'b0000 || Busy !== 1'b1 || Error !== 3'b000) begin
      errors++;
      $display("FAIL xfer_release: got %b/%b/%b expected 0000/1/000",
               BAGD, Busy, Error);
    end
    tick();
    checks++;
    if (Busy !== 1'b0 || BAGD !== 4'b0000) begin
      errors++;
      $display("FAIL xfer_idle: got %b/%b expected 0/0000",
               Busy, BAGD);
    end
    settle();
  endtask

  task automatic test_addr_timeout();
    BARQ = 4'b0001;
    tick();
    repeat (T - 1) tick();
    checks++;
    if (Error !== 3'b000 || BAGD !== 4'b0001) begin
      errors++;
      $display("FAIL addr_to_early: got %b/%b expected 000/0001",
               Error, BAGD);
    end
    tick();
    checks++;
    if (Error !== 3'b001 || BAGD !== 4'b0000) begin
      errors++;
      $display("FAIL addr_to: got %b/%b expected 001/0000",
               Error, BAGD);
    end
    BARQ   = 4'b0000;
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    checks++;
    if (Error !== 3'b000) begin
      errors++;
      $display("FAIL addr_to_clr: got %b expected 000", Error);
    end
    settle();
  endtask

  task automatic test_tgt_timeout();
    BARQ = 4'b0010;
    tick();
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    DataStrobe   = 1'b1;
    TargetReady  = 1'b0;
    repeat (T - 1) tick();
    TargetReady = 1'b1;
    tick();
    checks++;
    if (Error !== 3'b000 || BAGD !== 4'b0010) begin
      errors++;
      $display("FAIL tgt_15: got %b/%b expected 000/0010",
               Error, BAGD);
    end
    TargetReady = 1'b0;
    repeat (T) tick();
    checks++;
    if (Error !== 3'b010 || BAGD !== 4'b0000 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL tgt_to: got %b/%b/%b expected 010/0000/1",
               Error, BAGD, Busy);
    end
    quiet();
    repeat (2) tick();
  endtask

  task automatic test_proto_clr();
    DataStrobe = 1'b1;
    ErrClr     = 1'b1;
    tick();
    quiet();
    checks++;
    if (Error !== 3'b100 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL proto_clr: got %b/%b expected 100/0",
               Error, Busy);
    end
    settle();
  endtask

  task automatic test_async_reset();
    BARQ = 4'b1000;
    tick();
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    DataStrobe   = 1'b1;
    TargetReady  = 1'b1;
    tick();
    checks++;
    if (BAGD !== 4'b1000) begin
      errors++;
      $display("FAIL async_pre: got %b expected 1000", BAGD);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({BAGD, GrantId, Busy, Error} !== 10'b0) begin
      errors++;
      $display("FAIL async_drop: got %b expected %b",
               {BAGD, GrantId, Busy, Error}, 10'b0);
    end
    model_reset();
    quiet();
    BARQ = 4'b1111;
    @(posedge clk);
    #1 Reset_n = 1'b1;
    tick();
    checks++;
    if (BAGD !== 4'b0001 || GrantId !== 2'd0) begin
      errors++;
      $display("FAIL async_first: got %b/%0d expected 0001/0",
               BAGD, GrantId);
    end
    settle();
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    int tr_pct;
    req = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(99) < 8) req[b] = ~req[b];
      tr_pct       = (c % 400 < 200) ? 60 : 3;
      BARQ         = req;
      AddressValid = ($urandom_range(99) < 20);
      DataStrobe   = ($urandom_range(99) < 50);
      TargetReady  = ($urandom_range(99) < tr_pct);
      ErrClr       = ($urandom_range(99) < 4);
      tick();
      checks++;
      if ({BAGD, GrantId, Busy, Error} !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b expected %b", c,
                 {BAGD, GrantId, Busy, Error}, model_out());
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_transfer();
    test_addr_timeout();
    test_tgt_timeout();
    test_proto_clr();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_grant_sequencer.md
BUS_GRANT_SEQUENCER -- requirements
Module: bus_grant_sequencer

Interface
REQ-001 SHALL have parameter DeviceMaxNumber, default 4, number of bus requesters (2..16).
REQ-002 SHALL have parameter TimeoutCycles, default 16, watchdog limit in clk cycles (2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port BARQ  input  DeviceMaxNumber  bus request per device, synchronous to clk, level-held.
REQ-006 SHALL have port AddressValid  input  1  granted master drives a valid address.
REQ-007 SHALL have port TargetReady  input  1  target accepts data this cycle.
REQ-008 SHALL have port DataStrobe  input  1  master presents a data beat.
REQ-009 SHALL have port ErrClr  input  1  single-cycle clear of sticky errors.
REQ-010 SHALL have port BAGD  output  DeviceMaxNumber  bus grant; one-hot or all-zero.
REQ-011 SHALL have port GrantId  output  $clog2(DeviceMaxNumber)  index of granted device; 0 when idle.
REQ-012 SHALL have port Busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port Error  output  3  sticky flags: [0] address timeout, [1] target timeout, [2] protocol violation.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, RELEASE; all outputs registered.
REQ-015 IDLE: any BARQ bit high in cycle n SHALL give BAGD one-hot in cycle n+1 and enter ADDR.
REQ-016 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod DeviceMaxNumber; after reset last index = DeviceMaxNumber-1, so device 0 wins first.
REQ-017 ADDR: AddressValid high SHALL enter DATA next cycle; watchdog clears.
REQ-018 ADDR: granted BARQ bit low before AddressValid SHALL enter RELEASE with no error.
REQ-019 ADDR: TimeoutCycles consecutive cycles without AddressValid SHALL set Error[0] and enter RELEASE.
REQ-020 DATA: each cycle with DataStrobe and TargetReady both high is one beat; watchdog restarts on each beat.
REQ-021 DATA: granted BARQ bit low SHALL enter RELEASE; the beat in that same cycle, if any, still counts.
REQ-022 DATA: TimeoutCycles consecutive cycles with DataStrobe high and TargetReady low SHALL set Error[1] and enter RELEASE.
REQ-023 RELEASE: lasts exactly one cycle with BAGD = 0 (bus turnaround); last-index is updated; then IDLE, even if BARQ is pending.
REQ-024 Error[2] SHALL set on DataStrobe high in IDLE, ADDR or RELEASE, or on AddressValid high in IDLE or RELEASE; the FSM does not change state.
REQ-025 Error bits SHALL stay set until ErrClr; ErrClr and a new error in the same cycle leave that bit set.
REQ-026 The watchdog counter SHALL saturate, never wrap, and be sized $clog2(TimeoutCycles+1).
REQ-027 A request arriving while Busy SHALL wait; requests SHALL never be dropped or latched (level-sensed only).

Reset
REQ-028 Reset_n low SHALL immediately force: state IDLE, BAGD 0, GrantId 0, Busy 0, Error 0, watchdog 0, last index DeviceMaxNumber-1.
REQ-029 Reset mid-transfer SHALL drop the grant asynchronously; the first grant after release follows REQ-015.

Structure
REQ-030 A shared package SHALL hold the state enum type and the Error bit index constants (ERR_ADDR_TO=0, ERR_TGT_TO=1, ERR_PROTO=2).
REQ-031 The round-robin selector SHALL be a sub-module rr_priority_pick (request vector, last index, returns one-hot + index).

Verification
REQ-032 Reset release, BARQ=4'b0101 -> BAGD=4'b0001 one cycle later; after release with BARQ still 4'b0101 -> next BAGD=4'b0100.
REQ-033 Grant dev 2, AddressValid at cycle 3, 5 beats, BARQ[2] drops -> Busy high throughout, one RELEASE cycle with BAGD=0, then IDLE.
REQ-034 Grant, AddressValid held low 16 cycles -> Error=3'b001, BAGD=0 on the cycle after timeout; ErrClr -> Error=3'b000.
REQ-035 In DATA, DataStrobe=1 and TargetReady=0 for 16 cycles -> Error[1]=1, RELEASE; with 15 cycles then TargetReady=1 -> no error.
REQ-036 DataStrobe pulse in IDLE coincident with ErrClr -> Error=3'b100 after the edge.
REQ-037 Reset_n low in DATA -> BAGD=0 without a clock edge; all four BARQ high after reset -> device 0 granted first.
